// File: rtl/key_debounce_counter.sv
// key_debounce_counter
//   Conditions the raw pushbutton pins and packs the result into the 32-bit
//   word read by the buttons PIO. Each key has a two-flop synchronizer, a
//   debounce FSM and a wrapping 7-bit press counter. The host detects presses
//   by comparing successive counter reads.
//
// Parameters
//   NUM_KEYS        keys handled (1..4); byte k of buttons_word is key k
//   DEBOUNCE_CYCLES consecutive stable cycles needed to accept a change (>= 2)
//   KEY_ACTIVE_LOW  1: raw low = pressed, 0: raw high = pressed
//
// Ports
//   clk           fabric clock, rising edge
//   reset         synchronous, active-high
//   key_raw       asynchronous raw key pins
//   buttons_word  byte k = {press_count_k[6:0], level_k}; unused bytes are 0
//   press_pulse   one-cycle strobe per accepted press
module key_debounce_counter #(
  parameter int unsigned NUM_KEYS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [31:0]         buttons_word,
  output logic [NUM_KEYS-1:0] press_pulse
);

  localparam int unsigned CW = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
  // The edge that enters a pending state already counts as the first stable
  // cycle, so acceptance happens when the counter reaches DEBOUNCE_CYCLES-2.
  // This lands the level change DEBOUNCE_CYCLES+1 edges after the raw change
  // is first sampled.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PENDING,
    PRESSED,
    RELEASE_PENDING
  } state_e;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic          sync1_q;
    logic          sync2_q;
    logic          sample;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          level_q;
    logic [6:0]    count_q;
    logic          pulse_q;

    // Normalise to pressed = 1.
    assign sample = sync2_q ^ KEY_ACTIVE_LOW;

    always_ff @(posedge clk) begin
      if (reset) begin
        // Synchronizers hold the released pin level so a key held through
        // reset is debounced afresh and counted as a new press.
        sync1_q <= KEY_ACTIVE_LOW;
        sync2_q <= KEY_ACTIVE_LOW;
        state_q <= RELEASED;
        cnt_q   <= '0;
        level_q <= 1'b0;
        count_q <= '0;
        pulse_q <= 1'b0;
      end else begin
        sync1_q <= key_raw[k];
        sync2_q <= sync1_q;
        pulse_q <= 1'b0;
        case (state_q)
          RELEASED: begin
            if (sample) begin
              state_q <= PRESS_PENDING;
              cnt_q   <= '0;
            end
          end
          PRESS_PENDING: begin
            if (!sample) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
              level_q <= 1'b1;
              count_q <= count_q + 7'd1;
              pulse_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          PRESSED: begin
            if (!sample) begin
              state_q <= RELEASE_PENDING;
              cnt_q   <= '0;
            end
          end
          RELEASE_PENDING: begin
            if (sample) begin
              state_q <= PRESSED;
              cnt_q   <= '0;
            end else if (cnt_q == CNT_LAST) begin
              state_q <= RELEASED;
              cnt_q   <= '0;
              level_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= RELEASED;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign buttons_word[8*k +: 8] = {count_q, level_q};
    assign press_pulse[k]         = pulse_q;
  end

  for (genvar k = NUM_KEYS; k < 4; k++) begin : g_unused
    assign buttons_word[8*k +: 8] = '0;
  end

endmodule

// File: tb/tb_key_debounce_counter.sv
module tb_key_debounce_counter;

  localparam int unsigned D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_raw;
  logic [31:0] buttons_word;
  logic [3:0]  press_pulse;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  key_debounce_counter #(
    .NUM_KEYS        (4),
    .DEBOUNCE_CYCLES (D),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_raw      (key_raw),
    .buttons_word (buttons_word),
    .press_pulse  (press_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  raw;
    logic [31:0] exp_word;
    logic [3:0]  exp_pulse;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] raw, input logic [31:0] w,
                     input logic [3:0] p, input int n);
    vec_t v;
    v.rst = rst; v.raw = raw; v.exp_word = w; v.exp_pulse = p;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted level flips once the synchronised sample has
  // disagreed with it for D consecutive edges; sample = raw seen 2 edges ago.
  logic [3:0] hist[$];
  logic [3:0] m_level;
  int         m_count[4];
  int         m_run[4];
  logic [3:0] m_pulse;

  task automatic model_edge(input logic rst, input logic [3:0] raw);
    logic [3:0] s;
    logic       p;
    m_pulse = '0;
    if (rst) begin
      hist = {4'hF, 4'hF};
      m_level = '0;
      for (int k = 0; k < 4; k++) begin m_count[k] = 0; m_run[k] = 0; end
    end else begin
      hist.push_back(raw);
      while (hist.size() > 3) void'(hist.pop_front());
      s = hist[0];
      for (int k = 0; k < 4; k++) begin
        p = ~s[k];
        if (p != m_level[k]) begin
          m_run[k]++;
          if (m_run[k] == D) begin
            m_level[k] = p;
            m_run[k] = 0;
            if (p) begin
              m_count[k] = (m_count[k] + 1) % 128;
              m_pulse[k] = 1'b1;
            end
          end
        end else begin
          m_run[k] = 0;
        end
      end
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = {7'(m_count[k]), m_level[k]};
    return w;
  endfunction

  initial begin
    int unsigned pulses2;
    int unsigned bad_pulses;
    int          hold[4];

    // Reset and idle
    reset = 1'b1;
    key_raw = 4'hF;
    repeat (3) begin
      tick();
      chk("reset_word", buttons_word, 32'h0);
      chk("reset_pulse", {28'h0, press_pulse}, 32'h0);
    end
    reset = 1'b0;
    repeat (50) begin
      tick();
      chk("idle_word", buttons_word, 32'h0);
      chk("idle_pulse", {28'h0, press_pulse}, 32'h0);
    end

    // Table: key0 press/release, simultaneous keys 0+3, reset mid-pending
    add(0, 4'hE, 32'h0, 4'b0000, 5);
    add(0, 4'hE, 32'h3, 4'b0001, 1);
    add(0, 4'hE, 32'h3, 4'b0000, 1);
    add(0, 4'hF, 32'h3, 4'b0000, 5);
    add(0, 4'hF, 32'h2, 4'b0000, 2);
    add(1, 4'hF, 32'h0, 4'b0000, 2);
    add(0, 4'hF, 32'h0, 4'b0000, 3);
    add(0, 4'h6, 32'h0, 4'b0000, 5);
    add(0, 4'h6, 32'h03000003, 4'b1001, 1);
    add(0, 4'h6, 32'h03000003, 4'b0000, 1);
    add(0, 4'hF, 32'h03000003, 4'b0000, 5);
    add(0, 4'hF, 32'h02000002, 4'b0000, 1);
    add(1, 4'hF, 32'h0, 4'b0000, 2);
    add(0, 4'hF, 32'h0, 4'b0000, 3);
    add(0, 4'hE, 32'h0, 4'b0000, 4);
    add(1, 4'hE, 32'h0, 4'b0000, 3);
    add(0, 4'hE, 32'h0, 4'b0000, 5);
    add(0, 4'hE, 32'h3, 4'b0001, 1);
    add(0, 4'hE, 32'h3, 4'b0000, 1);
    add(0, 4'hF, 32'h3, 4'b0000, 5);
    add(0, 4'hF, 32'h2, 4'b0000, 1);
    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst;
      key_raw = tbl[i].raw;
      tick();
      chk($sformatf("tbl%0d_word", i), buttons_word, tbl[i].exp_word);
      chk($sformatf("tbl%0d_pulse", i), {28'h0, press_pulse}, {28'h0, tbl[i].exp_pulse});
    end
    reset = 1'b0;

    // Key1 bounce: 3 low, 1 high, 3 low, then high -- never accepted
    for (int i = 0; i < 16; i++) begin
      key_raw = (i < 3 || (i >= 4 && i < 7)) ? 4'hD : 4'hF;
      tick();
      chk("bounce_word", buttons_word, 32'h2);
      chk("bounce_pulse", {28'h0, press_pulse}, 32'h0);
    end

    // Key2: 130 clean presses, counter wraps
    pulses2 = 0;
    bad_pulses = 0;
    for (int i = 0; i < 130; i++) begin
      key_raw = 4'hB;
      repeat (7) begin
        tick();
        if (press_pulse[2]) pulses2++;
        if ((press_pulse & 4'b1011) != 4'b0000) bad_pulses++;
      end
      key_raw = 4'hF;
      repeat (7) begin
        tick();
        if (press_pulse != 4'b0000) bad_pulses++;
      end
      if (i == 126) chk("wrap_127", buttons_word, 32'h00FE0002);
      if (i == 127) chk("wrap_to_0", buttons_word, 32'h00000002);
    end
    chk("wrap_final", buttons_word, 32'h00040002);
    chk("wrap_pulses", pulses2, 130);
    chk("wrap_bad_pulses", bad_pulses, 0);

    // Randomised runs against the reference model
    reset = 1'b1;
    key_raw = 4'hF;
    tick();
    model_edge(1'b1, key_raw);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) hold[k] = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          key_raw[k] = 1'($urandom_range(0, 1));
          hold[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12))
                                                : int'($urandom_range(1, 5));
        end
        hold[k]--;
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
      model_edge(reset, key_raw);
      chk("rand_word", buttons_word, model_word());
      chk("rand_pulse", {28'h0, press_pulse}, {28'h0, m_pulse});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
